// File: rtl/dmi_request_bridge.sv
// dmi_request_bridge: turns one DTM DMI request at a time into a single-cycle
// Debug Module register access and returns a DMI status/data response.
module dmi_request_bridge #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned READ_LAT = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              dmi_req_valid,
   input  logic [1:0]        dmi_req_op,
   input  logic [ADDR_W-1:0] dmi_req_addr,
   input  logic [31:0]       dmi_req_data,
   input  logic              dmi_reset,
   output logic              dmi_resp_valid,
   input  logic              dmi_resp_ready,
   output logic [1:0]        dmi_resp_op,
   output logic [31:0]       dmi_resp_data,
   output logic [ADDR_W-1:0] dm_address,
   output logic [31:0]       dm_register_write,
   output logic              dm_write_en,
   output logic              dm_read_en,
   input  logic [31:0]       dm_register_read,
   output logic              sticky_busy
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned OP_W   = 2;
   localparam int unsigned CNT_W  = 2;
   localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'((READ_LAT > 0) ? READ_LAT - 1 : 0);

   localparam logic [OP_W-1:0] OP_NOP   = 2'd0;
   localparam logic [OP_W-1:0] OP_READ  = 2'd1;
   localparam logic [OP_W-1:0] OP_WRITE = 2'd2;

   localparam logic [OP_W-1:0] RSP_OK     = 2'd0;
   localparam logic [OP_W-1:0] RSP_FAILED = 2'd2;
   localparam logic [OP_W-1:0] RSP_BUSY   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [OP_W-1:0]     op_q, op_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                resp_valid_q, resp_valid_d;
   logic [OP_W-1:0]     resp_op_q, resp_op_d;
   logic [DATA_W-1:0]   resp_data_q, resp_data_d;
   logic                sticky_q, sticky_d;
   logic                busy_eff;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, latch and response decode
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      rdata_d      = rdata_q;
      resp_valid_d = resp_valid_q;
      resp_op_d    = resp_op_q;
      resp_data_d  = resp_data_q;
      sticky_d     = sticky_q;
      // dmi_reset clears the flag before an idle request looks at it
      busy_eff     = sticky_q && !dmi_reset;

      if (dmi_reset) begin
         sticky_d = 1'b0;
      end else if (dmi_req_valid && (state_q != ST_IDLE)) begin
         sticky_d = 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (dmi_req_valid) begin
               op_d = dmi_req_op;
               if (busy_eff) begin
                  resp_op_d    = RSP_BUSY;
                  resp_data_d  = rdata_q;
                  resp_valid_d = 1'b1;
                  state_d      = ST_RESP;
               end else if ((dmi_req_op == OP_READ) || (dmi_req_op == OP_WRITE)) begin
                  addr_d  = dmi_req_addr;
                  wdata_d = dmi_req_data;
                  state_d = ST_ISSUE;
               end else begin
                  resp_op_d    = (dmi_req_op == OP_NOP) ? RSP_OK : RSP_FAILED;
                  resp_data_d  = rdata_q;
                  resp_valid_d = 1'b1;
                  state_d      = ST_RESP;
               end
            end
         end
         ST_ISSUE: begin
            if (op_q == OP_WRITE) begin
               resp_op_d    = RSP_OK;
               resp_valid_d = 1'b1;
               state_d      = ST_RESP;
            end else if (READ_LAT == 0) begin
               rdata_d      = dm_register_read;
               resp_data_d  = dm_register_read;
               resp_op_d    = RSP_OK;
               resp_valid_d = 1'b1;
               state_d      = ST_RESP;
            end else begin
               cnt_d   = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == LAT_LAST) begin
               rdata_d      = dm_register_read;
               resp_data_d  = dm_register_read;
               resp_op_d    = RSP_OK;
               resp_valid_d = 1'b1;
               state_d      = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (dmi_resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q         <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cnt_q        <= '0;
         rdata_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_op_q    <= '0;
         resp_data_q  <= '0;
         sticky_q     <= 1'b0;
      end else begin
         op_q         <= op_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cnt_q        <= cnt_d;
         rdata_q      <= rdata_d;
         resp_valid_q <= resp_valid_d;
         resp_op_q    <= resp_op_d;
         resp_data_q  <= resp_data_d;
         sticky_q     <= sticky_d;
      end
   end

   // DM strobes decoded from state; address/data latches only move on a DM access
   assign dm_write_en       = (state_q == ST_ISSUE) && (op_q == OP_WRITE);
   assign dm_read_en        = (state_q == ST_ISSUE) && (op_q == OP_READ);
   assign dm_address        = addr_q;
   assign dm_register_write = wdata_q;

   assign dmi_resp_valid = resp_valid_q;
   assign dmi_resp_op    = resp_op_q;
   assign dmi_resp_data  = resp_data_q;
   assign sticky_busy    = sticky_q;

endmodule
